// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - op codes, FSM state and result types for mul_div_unit (optional MUL_DIV_MADD_EN)
package mul_div_pkg;

    localparam logic [3:0] OP_MULT  = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_MADD  = 4'b1001;
    localparam logic [3:0] OP_MADDU = 4'b1010;
    localparam logic [3:0] OP_MSUB  = 4'b0111;
    localparam logic [3:0] OP_MSUBU = 4'b1000;

    // Widest HI/LO the result struct can carry; the unit uses the low WIDTH bits.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] hi;
        logic [MAX_WIDTH-1:0] lo;
    } result_t;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MUL_DIV_MADD_EN
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
`ifdef MUL_DIV_MADD_EN
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
`else
        return (op == OP_MULT) || (op == OP_DIV);
`endif
    endfunction

    function automatic logic is_valid_op(input logic [3:0] op);
        return is_mul_op(op) || is_div_op(op);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - execute-stage request/response bundle for mul_div_unit
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, in1, in2, flush, hi_we, lo_we, wdata,
        input  ready, busy, done, hi, lo
    );

    modport slave (
        input  start, op, in1, in2, flush, hi_we, lo_we, wdata,
        output ready, busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit_div_iter.sv
// rtl/mul_div_unit_div_iter.sv - radix-2 restoring divider core on unsigned magnitudes
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Trial subtraction: shift the next dividend bit into the partial remainder.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    // Quotient bits enter at the LSB as dividend bits leave at the MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= shifted[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle HI/LO multiply/divide unit (optional MUL_DIV_MADD_EN)
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    mul_div_unit_if.slave        bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             accept;
    logic             commit;
    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] quo, rem;
    logic             div_load, div_step;
    logic [2*WIDTH-1:0] ext_a, ext_b, product, mul_res;
    result_t          res;

    assign accept   = (state_q == IDLE) && bus.start && is_valid_op(bus.op);
    assign commit   = (state_q == FIN) && !bus.flush;
    // First DIV cycle loads the magnitudes; the remaining WIDTH cycles each retire one bit.
    assign div_load = (state_q == DIV) && (cnt_q == CNT_W'(WIDTH));
    assign div_step = (state_q == DIV) && (cnt_q != CNT_W'(WIDTH));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; flush aborts any in-flight operation including its commit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = is_div_op(bus.op) ? DIV : MUL;
            MUL:  if (bus.flush) state_d = IDLE;
                  else if (cnt_q == '0) state_d = FIN;
            DIV:  if (bus.flush) state_d = IDLE;
                  else if (cnt_q == '0) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus.ready = (state_q == IDLE);
        bus.busy  = (state_q == MUL) || (state_q == DIV);
        bus.done  = commit;
    end

    // Operands and op are captured once at accept so later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= bus.op;
            a_q  <= bus.in1;
            b_q  <= bus.in2;
        end
    end

    // Latency counter: MUL runs MUL_CYCLES cycles, DIV runs WIDTH+1 (load plus WIDTH steps).
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= is_div_op(bus.op) ? CNT_W'(WIDTH) : CNT_W'(MUL_CYCLES - 1);
        end else if (((state_q == MUL) || (state_q == DIV)) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Sign handling and magnitudes feeding the unsigned divider.
    always_comb begin
        sgn   = is_signed_op(op_q);
        a_neg = sgn && a_q[WIDTH-1];
        b_neg = sgn && b_q[WIDTH-1];
        mag_a = a_neg ? -a_q : a_q;
        mag_b = b_neg ? -b_q : b_q;
    end

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quo),
        .remainder (rem)
    );

    // Full-width product; signed ops sign-extend both operands before multiplying.
    always_comb begin
        ext_a   = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b   = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        product = ext_a * ext_b;
        mul_res = product;
`ifdef MUL_DIV_MADD_EN
        if ((op_q == OP_MADD) || (op_q == OP_MADDU))
            mul_res = {hi_q, lo_q} + product;
        else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU))
            mul_res = {hi_q, lo_q} - product;
`endif
    end

    // Result selection with divide sign fixup and the divide-by-zero convention.
    always_comb begin
        res = '0;
        if (is_div_op(op_q)) begin
            if (b_q == '0) begin
                res.lo = MAX_WIDTH'({WIDTH{1'b1}});
                res.hi = MAX_WIDTH'(a_q);
            end else begin
                res.lo = MAX_WIDTH'((a_neg ^ b_neg) ? -quo : quo);
                res.hi = MAX_WIDTH'(a_neg ? -rem : rem);
            end
        end else begin
            res.hi = MAX_WIDTH'(mul_res[2*WIDTH-1:WIDTH]);
            res.lo = MAX_WIDTH'(mul_res[WIDTH-1:0]);
        end
    end

    // HI/LO: explicit MTHI/MTLO writes win over a same-cycle commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (bus.hi_we)   hi_q <= bus.wdata;
            else if (commit) hi_q <= res.hi[WIDTH-1:0];
            if (bus.lo_we)   lo_q <= bus.wdata;
            else if (commit) lo_q <= res.lo[WIDTH-1:0];
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed vector bench for mul_div_unit
module tb_mul_div_unit;
    import mul_div_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32), .MUL_CYCLES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[10];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   d0;
    int   lat;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge and count negedges until done; optionally MTHI in the done cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_hi_we, input logic [31:0] wd, output int n);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.in1 = a; bus.in2 = b;
        @(negedge clk);
        bus.start = 1'b0; bus.in1 = 32'h5A5A_1234; bus.in2 = 32'h0000_0009;
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_in_fin", {31'd0, bus.ready}, 32'd0);
        if (use_hi_we) begin
            bus.hi_we = 1'b1; bus.wdata = wd;
        end
        @(negedge clk);
        bus.hi_we = 1'b0;
    endtask

    initial begin
        vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 3};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3] = '{OP_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 33};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33};
        vecs[5] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[6] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
        vecs[7] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 33};
        vecs[8] = '{OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 3};
        vecs[9] = '{OP_MULTU, 32'h80000000, 32'd2,        32'd1,        32'd0,        3};

        reset = 1'b1;
        bus.start = 1'b0; bus.op = 4'd0; bus.in1 = '0; bus.in2 = '0;
        bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_hi",    bus.hi, 32'd0);
        check("reset_lo",    bus.lo, 32'd0);
        check("reset_ready", {31'd0, bus.ready}, 32'd1);
        check("reset_busy",  {31'd0, bus.busy},  32'd0);
        check("reset_done",  {31'd0, bus.done},  32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].in1, vecs[i].in2, 1'b0, 32'd0, lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
        end

        // Invalid op codes are ignored (HI=1, LO=0 from the last vector).
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'b0000; bus.in1 = 32'd5; bus.in2 = 32'd5;
        @(negedge clk);
        bus.op = 4'b1111;
        @(negedge clk);
        bus.start = 1'b0;
        check("invalid_ready", {31'd0, bus.ready}, 32'd1);
        check("invalid_busy",  {31'd0, bus.busy},  32'd0);
        repeat (5) @(negedge clk);
        check("invalid_hi",   bus.hi, 32'd1);
        check("invalid_lo",   bus.lo, 32'd0);
        check("invalid_done", done_cnt, d0);

        // Flush mid-DIVU with a simultaneous start: no done, HI/LO untouched.
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.in1 = 32'd100; bus.in2 = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1; bus.start = 1'b1; bus.op = OP_MULTU;
        @(negedge clk);
        bus.flush = 1'b0; bus.start = 1'b0;
        check("flush_ready", {31'd0, bus.ready}, 32'd1);
        check("flush_busy",  {31'd0, bus.busy},  32'd0);
        repeat (40) @(negedge clk);
        check("flush_no_done", done_cnt, d0);
        check("flush_hi", bus.hi, 32'd1);
        check("flush_lo", bus.lo, 32'd0);

        // MTHI in the FIN cycle wins for HI; LO still takes the product.
        run_op(OP_MULTU, 32'd2, 32'd3, 1'b1, 32'h0000ABCD, lat);
        check("mthi_fin_latency", lat, 3);
        check("mthi_fin_hi", bus.hi, 32'h0000ABCD);
        check("mthi_fin_lo", bus.lo, 32'd6);

        // MTLO while idle.
        bus.lo_we = 1'b1; bus.wdata = 32'h00001234;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo_idle_lo", bus.lo, 32'h00001234);
        check("mtlo_idle_hi", bus.hi, 32'h0000ABCD);

        // Reset in the middle of a divide.
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIV; bus.in1 = 32'hFFFFFFF9; bus.in2 = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_hi",    bus.hi, 32'd0);
        check("midreset_lo",    bus.lo, 32'd0);
        check("midreset_ready", {31'd0, bus.ready}, 32'd1);
        check("midreset_busy",  {31'd0, bus.busy},  32'd0);
        repeat (40) @(negedge clk);
        check("midreset_no_done", done_cnt, d0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
